mem_read_arbiter: RTL
=====================

// Module: mem_read_arbiter
// PURPOSE
//  Shares one asynchronous read-only word memory (combinational Do = M[A], ~25 ns
//  access) between two requesters, e.g. instruction fetch (port 0) and data load (port 1).
//  Registers the winning address onto the memory, waits a fixed number of cycles
//  for the access delay, captures the word and returns it with a 1-cycle ack pulse.
//  Round-robin arbitration; one transaction in flight at a time.
// PARAMETERS
//  ADDR_W       32  address width on requester and memory sides
//  DATA_W       32  data word width
//  WAIT_CYCLES  3   cycles mem_addr is held before mem_rdata is sampled (>=1; 3 @100 MHz covers 25 ns)
// PORTS
//  clk        in   1       single clock, rising-edge
//  rst_n      in   1       asynchronous, active-low reset
//  req0       in   1       port-0 read request (level, held until ack0)
//  addr0      in   ADDR_W  port-0 word address, stable while req0 high
//  ack0       out  1       1-cycle pulse: rdata0 valid
//  rdata0     out  DATA_W  port-0 read data, held until next ack0
//  req1       in   1       port-1 read request
//  addr1      in   ADDR_W  port-1 word address
//  ack1       out  1       1-cycle pulse: rdata1 valid
//  rdata1     out  DATA_W  port-1 read data, held until next ack1
//  mem_addr   out  ADDR_W  registered address to memory A input
//  mem_rdata  in   DATA_W  memory Do output
//  gnt0/gnt1  out  1       owner of current transaction (high in WAIT and DONE)
//  busy       out  1       high whenever state != IDLE
// BEHAVIOUR
//  Reset (rst_n=0, async): state=IDLE, all outputs 0, last_grant=1 (port 0 wins first tie).
//  FSM IDLE -> WAIT -> DONE -> IDLE:
//   IDLE: one req high -> grant it; both high -> grant port != last_grant. On grant edge:
//     mem_addr<=addrN, gntN<=1, last_grant<=N, cnt<=WAIT_CYCLES-1, ->WAIT. No req: stay.
//   WAIT: mem_addr held constant. cnt!=0: cnt--. cnt==0: rdataN<=mem_rdata, ->DONE.
//   DONE: ackN=1 for exactly this cycle; ->IDLE; gntN cleared on exit.
//  Latency: req sampled at grant edge E -> ackN high from edge E+WAIT_CYCLES to E+WAIT_CYCLES+1.
//  Throughput: held request re-arbitrated in IDLE; one transaction per WAIT_CYCLES+2 cycles.
//  ackN, rdataN registered; never ack0 and ack1 in same cycle; gnt0&gnt1 never both 1.
//  Req dropped mid-WAIT: transaction completes, ack still pulses (requester ignores).
//  addrN changes mid-WAIT: ignored; latched address used.
//  rst_n low mid-transaction: abort immediately, no ack, rdata cleared to 0.
//  Address not range-checked; full ADDR_W passed to memory.
// TESTING (bench: 10 ns clk, memory model with #25 Do, M[i]=32'hA000_0000+i)
//  1 Reset asserted mid-sim -> ack0/1=0, rdata0/1=0, mem_addr=0, gnt0/1=0, busy=0 at once.
//  2 req0=1,addr0=5 at edge 0 -> mem_addr=5 from edge 0, ack0 high edges 3-4, rdata0=A000_0005, ack1=0.
//  3 req0,req1 both high after reset (addr 2,7), drop each on ack -> ack0 edges 3-4 data A000_0002;
//    grant1 at edge 5, ack1 edges 8-9 data A000_0007.
//  4 req0,req1 held continuously -> grants alternate 0,1,0,1; each ack every 5 cycles, never overlap.
//  5 req1 dropped and addr1 changed 9->12 during WAIT -> ack1 still pulses, rdata1=A000_0009.
//  6 rst_n low at edge 2 of a port-0 read -> no ack0, busy=0; new req0 after release gives normal latency.

Source files
------------

// File: rtl/mem_read_arbiter.sv
// Round-robin read arbiter sharing one asynchronous word memory between two requesters.
// Each transaction holds the registered address for WAIT_CYCLES cycles, then captures the data and acks.
module mem_read_arbiter #(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int WAIT_CYCLES = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req0,
   input  logic [ADDR_W-1:0] addr0,
   output logic              ack0,
   output logic [DATA_W-1:0] rdata0,
   input  logic              req1,
   input  logic [ADDR_W-1:0] addr1,
   output logic              ack1,
   output logic [DATA_W-1:0] rdata1,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              gnt0,
   output logic              gnt1,
   output logic              busy
);

   localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WAIT_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t           state;
   state_t           state_next;
   logic [CNT_W-1:0] cnt;
   logic             last_grant;
   logic             grant_valid;
   logic             grant_port;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // On a tie the port that did not win last time is chosen.
   always_comb begin
      state_next  = state;
      grant_valid = 1'b0;
      grant_port  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (req0 || req1) begin
               grant_valid = 1'b1;
               state_next  = ST_WAIT;
               if (req0 && req1) begin
                  grant_port = ~last_grant;
               end else begin
                  grant_port = req1;
               end
            end
         end
         ST_WAIT: begin
            if (cnt == '0) begin
               state_next = ST_DONE;
            end
         end
         ST_DONE: begin
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_addr   <= '0;
         gnt0       <= 1'b0;
         gnt1       <= 1'b0;
         last_grant <= 1'b1;
         cnt        <= '0;
         ack0       <= 1'b0;
         ack1       <= 1'b0;
         rdata0     <= '0;
         rdata1     <= '0;
      end else begin
         ack0 <= 1'b0;
         ack1 <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (grant_valid) begin
                  mem_addr   <= grant_port ? addr1 : addr0;
                  gnt0       <= ~grant_port;
                  gnt1       <= grant_port;
                  last_grant <= grant_port;
                  cnt        <= CNT_INIT;
               end
            end
            ST_WAIT: begin
               if (cnt != '0) begin
                  cnt <= cnt - CNT_W'(1);
               end else if (gnt1) begin
                  rdata1 <= mem_rdata;
                  ack1   <= 1'b1;
               end else begin
                  rdata0 <= mem_rdata;
                  ack0   <= 1'b1;
               end
            end
            ST_DONE: begin
               gnt0 <= 1'b0;
               gnt1 <= 1'b0;
            end
            default: begin
               gnt0 <= 1'b0;
               gnt1 <= 1'b0;
            end
         endcase
      end
   end

   assign busy = (state != ST_IDLE);

endmodule
